core_pipe_buffer: RTL
=====================

// Module: core_pipe_buffer
// PURPOSE
// - Parametrised elastic buffer placed between two core pipeline stages (D->X, X->M, M->W).
// - Carries an opaque payload on a valid/ready handshake, with per-stage stall and flush inputs.
// - Replaces fixed single-entry stage registers with a DEPTH-entry circular queue.
// - Exposes occupancy and the head entry so hazard logic can inspect in-flight work.
// PARAMETERS
// - WIDTH      32  payload width in bits (>=1)
// - DEPTH      2   number of entries (1..8); DEPTH>=2 sustains 1 transfer/cycle with READY_REG=1
// - READY_REG  1   1: in_ready = !full (registered, no ready path); 0: in_ready = !full | pop
// - PERF_W     16  width of the performance counters (used only with CORE_PIPE_BUF_PERF_EN)
// PORTS
// - clk          in   1         core clock, all state on rising edge
// - rst_n        in   1         asynchronous active-low reset
// - in_valid     in   1         upstream payload valid
// - in_ready     out  1         buffer accepts the payload this cycle
// - in_data      in   WIDTH     upstream payload
// - out_valid    out  1         head entry presented downstream
// - out_ready    in   1         downstream consumes the head this cycle
// - out_data     out  WIDTH     head payload
// - stall        in   1         hazard unit freezes the output side
// - flush        in   1         branch unit discards all entries
// - count        out  $clog2(DEPTH+1)  current occupancy
// - stall_cnt    out  PERF_W    cycles with out_valid=0 because of stall (perf only)
// - bp_cnt       out  PERF_W    cycles with entries held because out_ready=0 (perf only)
// BEHAVIOUR
// - Reset: count=0, wr/rd ptr=0, out_valid=0, out_data=0, in_ready=1, perf counters=0.
// - push = in_valid & in_ready & !flush
// - pop  = out_valid & out_ready
// - Latency: min 1 cycle from push to out_valid. No combinational in_data->out_data path.
// - out_valid = (count!=0) & !stall. out_data = entry[rd_ptr], which is 0 when count==0.
// - Stability: while out_valid & !out_ready, out_data holds until pop.
// - Stall: blocks pop only. Pushes continue while space remains.
// - Full (count==DEPTH):
//   - READY_REG=1: in_ready=0.
//   - READY_REG=0: in_ready=pop, so a simultaneous push and pop keeps count==DEPTH.
// - Empty: a simultaneous push+pop is impossible because out_valid=0. count goes 0->1.
// - Pointers wrap modulo DEPTH; non-power-of-two DEPTH is required to work.
// - Flush, synchronous, highest priority:
//   - Next cycle: count=0, rd_ptr=wr_ptr=0, out_valid=0.
//   - An in_valid presented in the flush cycle is dropped (push=0).
//   - A pop in the flush cycle still completes downstream.
// - Async reset mid-transfer: all entries are lost immediately; the outputs take their reset values.
// - Handshake contract on the upstream side: in_valid must not drop, and in_data must not change, until in_ready. An assertion checks this in simulation.
// CONFIGURATION
// - `define CORE_PIPE_BUF_PERF_EN:
//   - stall_cnt increments when count!=0 & stall.
//   - bp_cnt increments when out_valid & !out_ready.
//   - Both counters saturate at all-ones and clear on flush.
// - Without the macro: stall_cnt and bp_cnt are tied to 0 and no counter flops are synthesised.
// STRUCTURE
// - core_pipe_pkg:
//   - occupancy width function cnt_w(DEPTH)
//   - typedef pipe_hs_t {valid, ready}
//   - localparam MAX_DEPTH=8
// - Optional sub-module core_pipe_buffer_mem: DEPTH x WIDTH register array with 1 write port and 1 async read port.
// - Pointer and count control stays in core_pipe_buffer.
// TESTING
// - DEPTH=2, READY_REG=1, out_ready=1, push 0x11,0x22,0x33 back-to-back
//     -> out_data 0x11,0x22,0x33 on cycles 1,2,3; count never exceeds 1.
// - DEPTH=3, out_ready=0, push 4 words
//     -> in_ready=0 after the 3rd push, count=3; release -> FIFO order, 4th accepted.
// - READY_REG=0, DEPTH=1, full, out_ready=1, in_valid=1
//     -> push+pop same cycle, count stays 1, one word/cycle.
// - count=2, flush=1 with in_valid=1 (0xAA)
//     -> next cycle count=0, out_valid=0, 0xAA never appears.
// - stall=1 for 3 cycles with count=1, PERF_EN
//     -> out_valid=0, stall_cnt=3, data unchanged after release.
// - rst_n low mid-stream with count=2
//     -> out_valid=0, count=0, in_ready=1 immediately; resume gives clean FIFO.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// Shared types and sizing helpers for the core pipeline elastic buffer.
package core_pipe_pkg;

  localparam int unsigned MAX_DEPTH = 8;

  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_hs_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/core_pipe_buffer_mem.sv
// DEPTH x WIDTH storage for core_pipe_buffer: one synchronous write port, one async read port.
module core_pipe_buffer_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents need no reset: the top masks the read data whenever it is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/core_pipe_buffer.sv
// DEPTH-entry elastic buffer between core pipeline stages with stall/flush control.
// Optional perf counters (stall_cnt, bp_cnt) are built when CORE_PIPE_BUF_PERF_EN is defined.
module core_pipe_buffer
  import core_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned READY_REG = 1,
  parameter int unsigned PERF_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      stall,
  input  logic                      flush,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [PERF_W-1:0]         stall_cnt,
  output logic [PERF_W-1:0]         bp_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("core_pipe_buffer: DEPTH out of range");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] head;
  logic             empty, full, rdy, push, pop;
  pipe_hs_t         up_hs, dn_hs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dn_hs = '{valid: !empty && !stall, ready: out_ready};
  assign pop   = dn_hs.valid && dn_hs.ready;
  // READY_REG=0 lets a full buffer accept when the head leaves in the same cycle.
  assign rdy   = (READY_REG != 0) ? !full : (!full || pop);
  assign up_hs = '{valid: in_valid, ready: rdy};
  assign push  = up_hs.valid && up_hs.ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  core_pipe_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign in_ready  = up_hs.ready;
  assign out_valid = dn_hs.valid;
  assign out_data  = empty ? '0 : head;
  assign count     = count_q;

`ifdef CORE_PIPE_BUF_PERF_EN
  logic [PERF_W-1:0] stall_q, bp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      bp_q    <= '0;
    end else if (flush) begin
      stall_q <= '0;
      bp_q    <= '0;
    end else begin
      if (!empty && stall && stall_q != '1)         stall_q <= stall_q + PERF_W'(1);
      if (dn_hs.valid && !out_ready && bp_q != '1) bp_q    <= bp_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign bp_cnt    = bp_q;
`else
  assign stall_cnt = '0;
  assign bp_cnt    = '0;
`endif

`ifndef SYNTHESIS
  // Upstream must hold an offered payload until it is taken; a flush cancels the offer.
  a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data)))
    else $error("core_pipe_buffer: in_valid/in_data changed before in_ready");
`endif

endmodule
